lfsr: RTL and testbench

- Fibonacci linear-feedback shift register (LFSR) with maximal-length feedback and a selectable width; default width 64.
- Produces a pseudo-random sequence of states, one new state per clock.
- Used as a seed / pattern source, e.g. a 64-bit state viewed as an 8x8 grid.
- The seed is loaded during reset; the register then free-runs.

---
 rtl/lfsr_pkg.sv | 43 ++++
 rtl/lfsr.sv | 54 +++++
 tb/tb_lfsr.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lfsr_pkg
// Brief  : Shared constants and helpers for the Fibonacci LFSR: the legal
//          widths, the fallback seed and the maximal-length tap masks.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package lfsr_pkg;

  // Fallback seed, substituted when an all-zero seed is presented in reset
  localparam logic [63:0] DEFAULT_SEED_64 = 64'h1;

  // Widths for which a maximal-length tap set is provided
  localparam int NUM_LEGAL_WIDTHS = 5;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{4, 8, 16, 32, 64};

  // True when the width has a tap set in tap_mask()
  function automatic bit is_legal_width(input int width);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == width) ok = 1'b1;
    end
    return ok;
  endfunction

  // Tap positions as a mask: tap n (1-based) sets bit n-1
  function automatic logic [63:0] tap_mask(input int width);
    logic [63:0] m;
    m = '0;
    case (width)
      4:       begin m[3]  = 1'b1; m[2]  = 1'b1;                              end
      8:       begin m[7]  = 1'b1; m[5]  = 1'b1; m[4]  = 1'b1; m[3]  = 1'b1; end
      16:      begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3]  = 1'b1; end
      32:      begin m[31] = 1'b1; m[21] = 1'b1; m[1]  = 1'b1; m[0]  = 1'b1; end
      64:      begin m[63] = 1'b1; m[62] = 1'b1; m[60] = 1'b1; m[59] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lfsr
// Brief  : Fibonacci LFSR with maximal-length feedback and selectable width.
//          Seed is loaded while reset is high (zero seed replaced by
//          DEFAULT_SEED); the register free-runs otherwise.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DEFAULT_SEED_64[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] shift_seed
);

  localparam logic [63:0]      C_TAP_MASK_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] C_TAP_MASK      = C_TAP_MASK_FULL[WIDTH-1:0];

  // Reject widths without a tap set and a zero fallback seed at elaboration
  if (!is_legal_width(WIDTH)) begin : g_bad_width
    $error("lfsr: WIDTH=%0d is not one of 4, 8, 16, 32, 64", WIDTH);
  end
  if (DEFAULT_SEED == '0) begin : g_bad_default_seed
    $error("lfsr: DEFAULT_SEED must be nonzero");
  end

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic [WIDTH-1:0] w_load;

  // Feedback bit and the value loaded under reset
  always_comb begin
    w_fb   = ^(r_state & C_TAP_MASK);
    w_load = (seed != '0) ? seed : DEFAULT_SEED;
  end

  // State register: reload under reset, otherwise shift left inserting feedback
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= w_load;
    end else begin
      r_state <= {r_state[WIDTH-2:0], w_fb};
    end
  end

  assign shift_seed = r_state;

endmodule : lfsr
`default_nettype wire

// File: tb/tb_lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_lfsr
// Brief  : Self-checking bench for lfsr at widths 4, 8 and 64. Expected states
//          come from an independent model and flow through a scoreboard queue.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_lfsr;

  logic        clk;
  logic        rst8,  rst64,  rst4;
  logic [7:0]  seed8;
  logic [63:0] seed64;
  logic [3:0]  seed4;
  logic [7:0]  sh8;
  logic [63:0] sh64;
  logic [3:0]  sh4;

  int n_cmp;
  int n_err;

  logic [63:0] q_exp[$];
  logic [63:0] m_state;

  lfsr #(.WIDTH(8))  u_w8  (.clk(clk), .reset(rst8),  .seed(seed8),  .shift_seed(sh8));
  lfsr #(.WIDTH(64)) u_w64 (.clk(clk), .reset(rst64), .seed(seed64), .shift_seed(sh64));
  lfsr #(.WIDTH(4))  u_w4  (.clk(clk), .reset(rst4),  .seed(seed4),  .shift_seed(sh4));

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] width_mask(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'h1 << w) - 64'h1);
  endfunction

  // Reference step, taps written out per width
  function automatic logic [63:0] model_next(input int w, input logic [63:0] s);
    logic fb;
    case (w)
      4:       fb = s[3] ^ s[2];
      8:       fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      default: fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    endcase
    return ((s << 1) | {63'b0, fb}) & width_mask(w);
  endfunction

  function automatic logic [63:0] read_dut(input int w);
    case (w)
      4:       return {60'b0, sh4};
      8:       return {56'b0, sh8};
      default: return sh64;
    endcase
  endfunction

  // One clock for DUT w: drive inputs, push expectation, clock, pop and compare
  task automatic cycle(input int w, input logic r, input logic [63:0] s, input string tag);
    logic [63:0] exp;
    logic [63:0] got;
    case (w)
      4:       begin rst4  = r; seed4  = s[3:0]; end
      8:       begin rst8  = r; seed8  = s[7:0]; end
      default: begin rst64 = r; seed64 = s;      end
    endcase
    if (r) exp = ((s & width_mask(w)) == 64'h0) ? 64'h1 : (s & width_mask(w));
    else   exp = model_next(w, m_state);
    q_exp.push_back(exp);
    @(posedge clk);
    #1;
    got = read_dut(w);
    if (q_exp.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'h1, 64'h0);
    end else begin
      exp = q_exp.pop_front();
      chk(tag, got, exp);
    end
    m_state = exp;
  endtask

  initial begin
    bit          seen [0:255];
    int          distinct;
    logic        zero_hit;
    logic        seed_hit;
    int          first_ret;
    logic [63:0] cur;

    n_cmp = 0;
    n_err = 0;
    m_state = '0;
    rst8 = 1'b0; rst64 = 1'b0; rst4 = 1'b0;
    seed8 = '0; seed64 = '0; seed4 = '0;
    @(negedge clk);

    // W8: seed 01, 5 reset cycles, then a full period
    for (int i = 0; i < 5; i++) cycle(8, 1'b1, 64'h01, "w8_reset");
    chk("w8_reset_value", read_dut(8), 64'h01);
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    zero_hit = 1'b0;
    first_ret = 0;
    for (int i = 1; i <= 255; i++) begin
      cycle(8, 1'b0, 64'h01, "w8_step");
      cur = read_dut(8);
      if (i == 1) chk("w8_first_step", cur, 64'h02);
      if (cur == 64'h0) zero_hit = 1'b1;
      if (!seen[cur[7:0]]) begin
        seen[cur[7:0]] = 1'b1;
        distinct++;
      end
      if (cur == 64'h01 && first_ret == 0) first_ret = i;
    end
    chk("w8_period", 64'(first_ret), 64'd255);
    chk("w8_distinct", 64'(distinct), 64'd255);
    chk("w8_no_zero", {63'b0, zero_hit}, 64'h0);

    // W8: zero seed falls back to DEFAULT_SEED, never reaches zero
    cycle(8, 1'b1, 64'h00, "w8_zero_seed_reset");
    chk("w8_zero_seed_default", read_dut(8), 64'h01);
    zero_hit = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      cycle(8, 1'b0, 64'h00, "w8_zero_seed_step");
      if (i == 1) chk("w8_zero_seed_first", read_dut(8), 64'h02);
      if (read_dut(8) == 64'h0) zero_hit = 1'b1;
    end
    chk("w8_zero_seed_no_zero", {63'b0, zero_hit}, 64'h0);

    // W8: mid-run reset reloads A5 and discards the sequence
    cycle(8, 1'b1, 64'h01, "w8_mid_reset0");
    for (int i = 0; i < 10; i++) cycle(8, 1'b0, 64'h01, "w8_mid_run");
    cycle(8, 1'b1, 64'hA5, "w8_mid_reload");
    chk("w8_mid_reload_value", read_dut(8), 64'hA5);
    cycle(8, 1'b0, 64'hA5, "w8_mid_after");
    chk("w8_mid_next", read_dut(8), 64'h4A);

    // W4: seed 9, period 15, seed changes while running are ignored
    cycle(4, 1'b1, 64'h9, "w4_reset");
    chk("w4_reset_value", read_dut(4), 64'h9);
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    first_ret = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(4, 1'b0, 64'($urandom_range(0, 15)), "w4_step");
      cur = read_dut(4);
      if (!seen[cur[7:0]]) begin
        seen[cur[7:0]] = 1'b1;
        distinct++;
      end
      if (cur == 64'h9 && first_ret == 0) first_ret = i;
    end
    chk("w4_period", 64'(first_ret), 64'd15);
    chk("w4_distinct", 64'(distinct), 64'd15);
    chk("w4_no_zero", {63'b0, seen[0]}, 64'h0);

    // W64: known first step, no return to seed within 2^16 steps
    cycle(64, 1'b1, 64'h0412_6424_0034_3C28, "w64_reset");
    chk("w64_reset_value", read_dut(64), 64'h0412_6424_0034_3C28);
    seed_hit = 1'b0;
    for (int i = 1; i <= 65536; i++) begin
      cycle(64, 1'b0, 64'h0412_6424_0034_3C28, "w64_step");
      if (i == 1) chk("w64_first_step", read_dut(64), 64'h0824_C848_0068_7850);
      if (read_dut(64) == 64'h0412_6424_0034_3C28) seed_hit = 1'b1;
    end
    chk("w64_no_return", {63'b0, seed_hit}, 64'h0);

    chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_lfsr
`default_nettype wire
